// File: rtl/done_capture_guard_pkg.sv
// Shared types and default parameters for the done-capture guard block.
// Holds the FSM state encoding and the alarm cause codes reported on alarm_code.
package done_guard_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ALM_NONE     = 2'b00,
    ALM_SPURIOUS = 2'b01,
    ALM_TIMEOUT  = 2'b10,
    ALM_LATENCY  = 2'b11
  } alarm_code_t;

  localparam int DW_DEF       = 128;
  localparam int DEPTH_DEF    = 2;
  localparam int TIMEOUT_DEF  = 16;
  localparam int DONE_LAT_DEF = 12;

endpackage

// File: rtl/done_capture_guard_if.sv
// Upstream ld/done/data and downstream valid/ready signals of the capture guard.
// master = datapath + consumer side, slave = the guard itself.
interface done_capture_guard_if
  import done_guard_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic          ld;
  logic          done;
  logic [DW-1:0] data_in;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output ld, done, data_in, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  ld, done, data_in, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/done_capture_guard_capture_fifo.sv
// Small synchronous FIFO holding captured cipher words; head is presented combinationally.
// A separate occupancy counter distinguishes full from empty since pointers wrap modulo DEPTH.
module capture_fifo
  import done_guard_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [DW-1:0]    mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [DEPTH-1:0] wr_en;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_FULL);
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = do_push && (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        mem_reg[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/done_capture_guard.sv
// Capture guard behind the round-counter done generator: buffers legal results, alarms on done faults.
// Optional macro DONE_LAT_CHECK_EN: a done at any wcnt other than DONE_LAT raises the latency alarm.
module done_capture_guard
  import done_guard_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int DONE_LAT = DONE_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  done_capture_guard_if.slave  bus,
  output logic                 busy,
  output logic                 alarm,
  output logic [1:0]           alarm_code,
  output logic                 overflow
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WCNT_ONE = WCW'(1);
  localparam logic [WCW-1:0] WCNT_MAX = WCW'(TIMEOUT);
  localparam logic [WCW-1:0] WCNT_LAT = WCW'(DONE_LAT);

`ifdef DONE_LAT_CHECK_EN
  localparam bit LAT_CHECK = 1'b1;
`else
  localparam bit LAT_CHECK = 1'b0;
`endif

  state_t         state_reg;
  logic [WCW-1:0] wcnt_reg;
  logic           busy_reg;
  logic           alarm_reg;
  alarm_code_t    alarm_code_reg;
  logic           overflow_reg;

  logic           lat_bad;
  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [DW-1:0]  fifo_head;

  assign lat_bad = LAT_CHECK && (wcnt_reg != WCNT_LAT);
  assign push    = (state_reg == RUN) && bus.done && !lat_bad;
  assign pop     = bus.out_valid && bus.out_ready;

  // Head is hidden once alarmed so a faulted result can never leak downstream.
  assign bus.out_valid = !fifo_empty && !alarm_reg;
  assign bus.out_data  = bus.out_valid ? fifo_head : '0;

  assign busy       = busy_reg;
  assign alarm      = alarm_reg;
  assign alarm_code = alarm_code_reg;
  assign overflow   = overflow_reg;

  capture_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_capture_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.data_in),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      wcnt_reg       <= '0;
      busy_reg       <= 1'b0;
      alarm_reg      <= 1'b0;
      alarm_code_reg <= ALM_NONE;
    end else begin
      case (state_reg)
        IDLE: begin
          // A done with no operation in flight wins over a simultaneous ld.
          if (bus.done) begin
            state_reg      <= ALARM;
            alarm_reg      <= 1'b1;
            alarm_code_reg <= ALM_SPURIOUS;
          end else if (bus.ld) begin
            state_reg <= RUN;
            wcnt_reg  <= WCNT_ONE;
            busy_reg  <= 1'b1;
          end
        end

        RUN: begin
          if (bus.done) begin
            if (lat_bad) begin
              state_reg      <= ALARM;
              busy_reg       <= 1'b0;
              alarm_reg      <= 1'b1;
              alarm_code_reg <= ALM_LATENCY;
            end else if (bus.ld) begin
              wcnt_reg <= WCNT_ONE;
            end else begin
              state_reg <= IDLE;
              wcnt_reg  <= '0;
              busy_reg  <= 1'b0;
            end
          end else if (bus.ld) begin
            wcnt_reg <= WCNT_ONE;
          end else if (wcnt_reg == WCNT_MAX) begin
            state_reg      <= ALARM;
            busy_reg       <= 1'b0;
            alarm_reg      <= 1'b1;
            alarm_code_reg <= ALM_TIMEOUT;
          end else begin
            wcnt_reg <= wcnt_reg + 1'b1;
          end
        end

        ALARM: begin
          state_reg <= ALARM;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_done_capture_guard.sv
// Bench for done_capture_guard: vector table, directed multi-cycle sequences, randomized episodes vs a queue model.
module tb_done_capture_guard;

  localparam int DW       = 128;
  localparam int DEPTH    = 2;
  localparam int TIMEOUT  = 16;
  localparam int DONE_LAT = 12;

`ifdef DONE_LAT_CHECK_EN
  localparam bit LAT_CHK = 1'b1;
`else
  localparam bit LAT_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy;
  logic          alarm;
  logic [1:0]    alarm_code;
  logic          overflow;

  done_capture_guard_if #(.DW(DW)) bus ();

  done_capture_guard #(
    .DW       (DW),
    .DEPTH    (DEPTH),
    .TIMEOUT  (TIMEOUT),
    .DONE_LAT (DONE_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .alarm      (alarm),
    .alarm_code (alarm_code),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: operation in flight, cycles since ld, first fault code, overflow, result queue.
  bit            m_run;
  int            m_age;
  int            m_code;
  bit            m_ovf;
  logic [DW-1:0] m_q[$];

  typedef struct {
    logic       ld;
    logic       done;
    logic       rdy;
    logic       e_busy;
    logic       e_alarm;
    logic [1:0] e_code;
    logic       e_valid;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_age  = 0;
    m_code = 0;
    m_ovf  = 1'b0;
    m_q.delete();
  endtask

  task automatic check_model(input string tag);
    logic          e_valid;
    logic [DW-1:0] e_data;
    e_valid = (m_q.size() > 0) && (m_code == 0);
    e_data  = e_valid ? m_q[0] : '0;
    chk({tag, "_busy"},  busy,          m_run);
    chk({tag, "_alarm"}, alarm,         m_code != 0);
    chk({tag, "_code"},  alarm_code,    m_code);
    chk({tag, "_ovf"},   overflow,      m_ovf);
    chk({tag, "_valid"}, bus.out_valid, e_valid);
    chk({tag, "_data"},  bus.out_data,  e_data);
  endtask

  task automatic model_step(input logic l, input logic d, input logic [DW-1:0] din, input logic rdy);
    bit pop;
    bit push;
    int size0;
    size0 = m_q.size();
    pop   = (size0 > 0) && (m_code == 0) && rdy;
    push  = 1'b0;
    if (m_code != 0) begin
      // fault state absorbs everything
    end else if (!m_run) begin
      if (d) m_code = 1;
      else if (l) begin
        m_run = 1'b1;
        m_age = 1;
      end
    end else if (d) begin
      if (LAT_CHK && m_age != DONE_LAT) begin
        m_code = 3;
        m_run  = 1'b0;
      end else begin
        push = 1'b1;
        if (l) m_age = 1;
        else m_run = 1'b0;
      end
    end else if (l) begin
      m_age = 1;
    end else if (m_age >= TIMEOUT) begin
      m_code = 2;
      m_run  = 1'b0;
    end else begin
      m_age++;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (size0 < DEPTH || pop) m_q.push_back(din);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic cycle(input logic l, input logic d, input logic [DW-1:0] din,
                       input logic rdy, input string tag);
    bus.ld        = l;
    bus.done      = d;
    bus.data_in   = din;
    bus.out_ready = rdy;
    model_step(l, d, din, rdy);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    bus.ld        = 1'b0;
    bus.done      = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_model("rst");
  endtask

  task automatic run_op(input logic [DW-1:0] data, input logic rdy, input string tag);
    cycle(1'b1, 1'b0, '0, rdy, tag);
    for (int i = 0; i < DONE_LAT - 1; i++) cycle(1'b0, 1'b0, '0, rdy, tag);
    cycle(1'b0, 1'b1, data, rdy, tag);
  endtask

  initial begin
    logic [DW-1:0] ka;
    logic [DW-1:0] kb;
    logic [DW-1:0] kc;
    logic [DW-1:0] kd;
    ka = 128'h3925841D02DC09FBDC118597196A0B32;
    kb = 128'h00112233445566778899AABBCCDDEEFF;
    kc = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;
    kd = 128'hA5A5A5A55A5A5A5AF0F0F0F00F0F0F0F;

    bus.ld = 1'b0; bus.done = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0;
    model_reset();
    #12;
    chk("por_busy", busy, 1'b0);
    chk("por_alarm", alarm, 1'b0);
    chk("por_valid", bus.out_valid, 1'b0);

    // Spurious done (with ld) from IDLE, then everything ignored.
    vt[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
    vt[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(vt[i].ld, vt[i].done, kd, vt[i].rdy, "tbl");
      chk("tbl_busy",  busy,          vt[i].e_busy);
      chk("tbl_alarm", alarm,         vt[i].e_alarm);
      chk("tbl_code",  alarm_code,    vt[i].e_code);
      chk("tbl_valid", bus.out_valid, vt[i].e_valid);
    end

    // Normal capture at the nominal latency.
    do_reset();
    cycle(1'b1, 1'b0, '0, 1'b1, "t1");
    for (int i = 0; i < DONE_LAT - 1; i++) cycle(1'b0, 1'b0, '0, 1'b1, "t1");
    chk("t1_busy_pre", busy, 1'b1);
    cycle(1'b0, 1'b1, ka, 1'b1, "t1");
    chk("t1_valid", bus.out_valid, 1'b1);
    chk("t1_data", bus.out_data, ka);
    chk("t1_busy_post", busy, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, "t1");
    chk("t1_popped", bus.out_valid, 1'b0);
    chk("t1_alarm", alarm, 1'b0);

    // Missing done: timeout alarm.
    do_reset();
    cycle(1'b1, 1'b0, '0, 1'b1, "t3");
    for (int i = 0; i < TIMEOUT - 1; i++) cycle(1'b0, 1'b0, '0, 1'b1, "t3");
    chk("t3_no_alarm_yet", alarm, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, "t3");
    chk("t3_alarm", alarm, 1'b1);
    chk("t3_code", alarm_code, 2'b10);
    chk("t3_busy", busy, 1'b0);

    // Overflow: consumer stalled across three operations.
    do_reset();
    run_op(ka, 1'b0, "t4");
    run_op(kb, 1'b0, "t4");
    run_op(kc, 1'b0, "t4");
    chk("t4_valid", bus.out_valid, 1'b1);
    chk("t4_head_a", bus.out_data, ka);
    chk("t4_ovf", overflow, 1'b1);
    chk("t4_alarm", alarm, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, "t4");
    chk("t4_head_b", bus.out_data, kb);
    cycle(1'b0, 1'b0, '0, 1'b1, "t4");
    chk("t4_drained", bus.out_valid, 1'b0);

    // Early done at wcnt=8.
    do_reset();
    cycle(1'b1, 1'b0, '0, 1'b0, "t5");
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, '0, 1'b0, "t5");
    cycle(1'b0, 1'b1, kd, 1'b0, "t5");
    if (LAT_CHK) begin
      chk("t5_code", alarm_code, 2'b11);
      chk("t5_valid", bus.out_valid, 1'b0);
    end else begin
      chk("t5_code", alarm_code, 2'b00);
      chk("t5_data", bus.out_data, kd);
    end

    // Async reset mid-operation, then a stale done.
    do_reset();
    run_op(kb, 1'b0, "t6");
    cycle(1'b1, 1'b0, '0, 1'b0, "t6");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0, "t6");
    chk("t6_busy_pre", busy, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_valid", bus.out_valid, 1'b0);
    chk("t6_rst_data", bus.out_data, '0);
    chk("t6_rst_alarm", alarm, 1'b0);
    chk("t6_rst_code", alarm_code, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b0, 1'b1, kd, 1'b1, "t6");
    chk("t6_stale_code", alarm_code, 2'b01);

    // Randomized episodes against the model.
    for (int ep = 0; ep < 25; ep++) begin
      int ld_odds;
      ld_odds = $urandom_range(6, 20);
      do_reset();
      for (int c = 0; c < 200; c++) begin
        logic l;
        logic d;
        l = ($urandom_range(0, ld_odds - 1) == 0);
        if (m_run && m_age == DONE_LAT) d = ($urandom_range(0, 1) == 1);
        else d = ($urandom_range(0, 59) == 0);
        cycle(l, d, {$urandom(), $urandom(), $urandom(), $urandom()},
              $urandom_range(0, 2) != 0, "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
